// File: rtl/sample_capture_pkg.sv
// Shared definitions for the sampling-tick interface: capture FSM states,
// mode range and default sample/FIFO sizing used with the sampling controller.
package sample_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FLUSH = 2'd2
  } cap_state_e;

  localparam int MODE_MAX  = 4;
  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/sample_capture_fifo.sv
// Synchronous FIFO with push, pop and single-cycle clear; pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
module sample_fifo
  import sample_capture_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 4
) (
  input  logic          Fg_clk,
  input  logic          Resetn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero when nothing is buffered.
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !clr_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/sample_capture.sv
// Capture side of the sampling-tick interface: arms on Ready, buffers one
// sample per Enable strobe, and flushes whenever the rate mode changes.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 4,
  parameter int CW    = 16
) (
  input  logic          Fg_clk,
  input  logic          Resetn,
  input  logic          Ready,
  input  logic          Enable,
  input  logic [2:0]    Mode,
  input  logic [DW-1:0] SampleIn,
  output logic [DW-1:0] OutData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          Armed,
  output logic          Overflow,
  output logic [AW:0]   FillLevel,
  output logic [CW-1:0] SampleCnt
);

  localparam logic [CW-1:0] CNT_ONE = 1;

  cap_state_e    state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, clr;
  logic          fifo_full, fifo_empty;

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Ready) begin
          state_d = ST_ARMED;
          mode_d  = Mode;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        // A rate change freezes both FIFO ports for this cycle and the flush cycle.
        if (Mode != mode_q) begin
          state_d = ST_FLUSH;
          mode_d  = Mode;
          clr     = 1'b1;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          pop = !fifo_empty && OutReady;
          if (Enable) begin
            if (!fifo_full || pop) begin
              push  = 1'b1;
              cnt_d = cnt_q + CNT_ONE;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      ST_FLUSH: state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
  end

  sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .Fg_clk  (Fg_clk),
    .Resetn  (Resetn),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (clr),
    .wdata_i (SampleIn),
    .rdata_o (OutData),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (FillLevel)
  );

  assign OutValid  = !fifo_empty;
  assign Armed     = (state_q != ST_IDLE);
  assign Overflow  = ovf_q;
  assign SampleCnt = cnt_q;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture: arming, capture/drain order, full and
// overflow handling, mode-change flush, mid-run reset and slow-mode strobes.
module tb_sample_capture;

  logic        Fg_clk = 1'b0;
  logic        Resetn;
  logic        Ready;
  logic        Enable;
  logic [2:0]  Mode;
  logic [7:0]  SampleIn;
  logic [7:0]  OutData;
  logic        OutValid;
  logic        OutReady;
  logic        Armed;
  logic        Overflow;
  logic [4:0]  FillLevel;
  logic [15:0] SampleCnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Fg_clk = ~Fg_clk;

  sample_capture dut (
    .Fg_clk    (Fg_clk),
    .Resetn    (Resetn),
    .Ready     (Ready),
    .Enable    (Enable),
    .Mode      (Mode),
    .SampleIn  (SampleIn),
    .OutData   (OutData),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Armed     (Armed),
    .Overflow  (Overflow),
    .FillLevel (FillLevel),
    .SampleCnt (SampleCnt)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Fg_clk);
    #1;
  endtask

  task automatic arm(input logic [2:0] m);
    Mode  = m;
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
  endtask

  task automatic pulse_reset();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
  endtask

  int vcnt;

  initial begin
    Resetn   = 1'b0;
    Ready    = 1'b0;
    Enable   = 1'b0;
    Mode     = 3'd0;
    SampleIn = 8'h00;
    OutReady = 1'b0;
    tick();
    tick();
    chk_eq("rst_armed", Armed, 0);
    chk_eq("rst_valid", OutValid, 0);
    chk_eq("rst_level", FillLevel, 0);
    chk_eq("rst_cnt", SampleCnt, 0);
    chk_eq("rst_ovf", Overflow, 0);
    chk_eq("rst_data", OutData, 0);
    Resetn = 1'b1;

    // Strobes before arming are ignored
    Enable   = 1'b1;
    SampleIn = 8'h11;
    repeat (5) tick();
    Enable = 1'b0;
    chk_eq("idle_level", FillLevel, 0);
    chk_eq("idle_armed", Armed, 0);
    chk_eq("idle_valid", OutValid, 0);

    // Capture four samples in mode 0, then drain in order
    arm(3'd0);
    chk_eq("arm_armed", Armed, 1);
    Enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      SampleIn = 8'(i);
      tick();
    end
    Enable = 1'b0;
    chk_eq("cap4_level", FillLevel, 4);
    chk_eq("cap4_cnt", SampleCnt, 4);
    chk_eq("cap4_head", OutData, 1);
    chk_eq("cap4_valid", OutValid, 1);
    OutReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk_eq("drain_valid", OutValid, 1);
      chk_eq("drain_data", OutData, 32'(i));
      tick();
    end
    chk_eq("drain_empty", OutValid, 0);
    chk_eq("drain_level", FillLevel, 0);
    OutReady = 1'b0;

    // Fill to full with 20 strobes; strobe 17 onward overflows
    pulse_reset();
    arm(3'd0);
    Enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      SampleIn = 8'h20 + 8'(i);
      tick();
      if (i == 15) chk_eq("full_no_ovf", Overflow, 0);
      if (i == 16) chk_eq("ovf_at_17", Overflow, 1);
    end
    chk_eq("full_level", FillLevel, 16);
    chk_eq("full_cnt", SampleCnt, 16);
    chk_eq("full_ovf", Overflow, 1);
    chk_eq("full_head", OutData, 8'h20);
    SampleIn = 8'hAA;
    OutReady = 1'b1;
    tick();
    chk_eq("fullpp_level", FillLevel, 16);
    chk_eq("fullpp_head", OutData, 8'h21);
    chk_eq("fullpp_cnt", SampleCnt, 17);
    chk_eq("fullpp_ovf", Overflow, 1);
    Enable = 1'b0;
    repeat (10) tick();
    OutReady = 1'b0;
    chk_eq("pre_flush_level", FillLevel, 6);
    chk_eq("pre_flush_ovf", Overflow, 1);

    // Mode change 0->2 flushes; strobe during flush cycle is dropped
    Mode = 3'd2;
    tick();
    chk_eq("flush_level", FillLevel, 0);
    chk_eq("flush_ovf", Overflow, 0);
    chk_eq("flush_cnt", SampleCnt, 0);
    chk_eq("flush_valid", OutValid, 0);
    Enable   = 1'b1;
    SampleIn = 8'h99;
    tick();
    chk_eq("flushcyc_level", FillLevel, 0);
    chk_eq("flushcyc_armed", Armed, 1);
    SampleIn = 8'h77;
    tick();
    Enable = 1'b0;
    chk_eq("postflush_level", FillLevel, 1);
    chk_eq("postflush_head", OutData, 8'h77);
    chk_eq("postflush_cnt", SampleCnt, 1);

    // Reset with buffered data, then strobes without a new Ready
    Enable   = 1'b1;
    SampleIn = 8'h01;
    tick();
    SampleIn = 8'h02;
    tick();
    Enable = 1'b0;
    chk_eq("prerst_level", FillLevel, 3);
    Resetn = 1'b0;
    #2;
    chk_eq("asyncrst_level", FillLevel, 0);
    chk_eq("asyncrst_armed", Armed, 0);
    chk_eq("asyncrst_valid", OutValid, 0);
    tick();
    Resetn = 1'b1;
    Enable = 1'b1;
    repeat (3) tick();
    Enable = 1'b0;
    chk_eq("rerst_level", FillLevel, 0);
    chk_eq("rerst_armed", Armed, 0);
    chk_eq("rerst_cnt", SampleCnt, 0);

    // Slow mode 4: each sample visible for exactly one cycle after its strobe
    arm(3'd4);
    OutReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      Enable   = 1'b1;
      SampleIn = 8'h40 + 8'(k);
      tick();
      Enable = 1'b0;
      chk_eq("slow_valid", OutValid, 1);
      chk_eq("slow_data", OutData, 32'(8'h40 + 8'(k)));
      vcnt = 0;
      for (int c = 0; c < 9999; c++) begin
        tick();
        if (OutValid) vcnt++;
      end
      chk_eq("slow_extra_valid", vcnt, 0);
    end
    chk_eq("slow_cnt", SampleCnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
